// File: rtl/sort_sequencer.sv
// Serial odd-even transposition sorter: loads N records, sorts them by the nibble-swapped key
// one phase per clock with early exit, then streams them out in ascending key order.

module sort_sequencer_cas (
  input  logic       i_en,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_lo,
  output logic [7:0] o_hi,
  output logic       o_swp
);
  // Low nibble is the primary field, so the key is the record with its nibbles swapped.
  assign o_swp = i_en && ({i_a[3:0], i_a[7:4]} > {i_b[3:0], i_b[7:4]});
  assign o_lo  = o_swp ? i_b : i_a;
  assign o_hi  = o_swp ? i_a : i_b;
endmodule

module sort_sequencer #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [$clog2(N):0]     sort_phases
);
  localparam int IW = $clog2(N);
  localparam int PW = IW + 1;
  localparam logic [IW-1:0] LAST_I = IW'(N - 1);
  localparam logic [PW-1:0] LAST_P = PW'(N - 1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t                r_state;
  logic [N-1:0][W-1:0]   r_mem;
  logic [IW-1:0]         r_wr_idx;
  logic [IW-1:0]         r_rd_idx;
  logic [PW-1:0]         r_p;
  logic                  r_prev_clean;

  logic [N-2:0]          w_en;
  logic [N-2:0]          w_swp;
  logic [N-2:0][W-1:0]   w_lo;
  logic [N-2:0][W-1:0]   w_hi;
  logic [N-1:0][W-1:0]   w_nxt;
  logic                  w_clean;
  logic                  w_exit;

  // Pair (i,i+1) is active when its lower index parity matches the phase parity.
  for (genvar i = 0; i < N - 1; i++) begin : g_cas
    assign w_en[i] = (r_state == SORT) && (r_p[0] == 1'(i % 2));
    sort_sequencer_cas u_cas (
      .i_en  (w_en[i]),
      .i_a   (r_mem[i]),
      .i_b   (r_mem[i+1]),
      .o_lo  (w_lo[i]),
      .o_hi  (w_hi[i]),
      .o_swp (w_swp[i])
    );
  end

  always_comb begin
    w_nxt = r_mem;
    for (int j = 0; j < N - 1; j++) begin
      if (w_en[j]) begin
        w_nxt[j]   = w_lo[j];
        w_nxt[j+1] = w_hi[j];
      end
    end
  end

  assign w_clean = ~|w_swp;
  // Two clean phases in a row cover both parities, so the array is already ordered.
  assign w_exit  = (w_clean && r_prev_clean) || (r_p == LAST_P);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD;
      r_mem        <= '0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_p          <= '0;
      r_prev_clean <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      sort_phases  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid && in_ready) begin
            r_mem[r_wr_idx] <= in_data;
            if (r_wr_idx == LAST_I) begin
              r_wr_idx     <= '0;
              r_p          <= '0;
              r_prev_clean <= 1'b0;
              in_ready     <= 1'b0;
              busy         <= 1'b1;
              r_state      <= SORT;
            end else begin
              r_wr_idx <= r_wr_idx + 1'b1;
            end
          end
        end
        SORT: begin
          r_mem        <= w_nxt;
          r_prev_clean <= w_clean;
          if (w_exit) begin
            sort_phases <= r_p + 1'b1;
            r_rd_idx    <= '0;
            out_valid   <= 1'b1;
            out_data    <= w_nxt[0];
            r_state     <= DRAIN;
          end else begin
            r_p <= r_p + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_rd_idx == LAST_I) begin
              r_rd_idx  <= '0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              r_state   <= LOAD;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
              out_data <= r_mem[r_rd_idx + 1'b1];
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_sequencer.sv
// Randomized bench for sort_sequencer: a key-ordered reference plus a phase-count model,
// with a per-cycle output monitor and a few literal pins on the model.
module tb_sort_sequencer;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int PW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [PW-1:0] sort_phases;

  sort_sequencer #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .sort_phases(sort_phases)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] blk[8];
  logic [7:0] srt[8];
  int exp_k;

  function automatic logic [7:0] key(input logic [7:0] x);
    return {x[3:0], x[7:4]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected order is a plain key sort; phase count comes from running the phase rules on an array.
  task automatic model();
    logic [7:0] a[8];
    logic [7:0] b[8];
    logic [7:0] t;
    bit pc, sw;
    a = blk; pc = 0; exp_k = 0;
    for (int p = 0; p < N; p++) begin
      b = a; sw = 0;
      for (int i = p % 2; i + 1 < N; i += 2)
        if (key(a[i]) > key(a[i+1])) begin b[i] = a[i+1]; b[i+1] = a[i]; sw = 1; end
      a = b;
      if ((!sw && pc) || p == N - 1) begin exp_k = p + 1; break; end
      pc = !sw;
    end
    srt = blk;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (key(srt[j]) < key(srt[i])) begin t = srt[i]; srt[i] = srt[j]; srt[j] = t; end
  endtask

  // Output monitor: every valid cycle must show the next expected record, held while stalled.
  initial begin
    logic prev_stall;
    logic [7:0] prev_data;
    prev_stall = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) chk("stale_out", 1, 0);
        else chk("out_data", out_data, exp_q[0]);
        chk("in_ready_drain", in_ready, 0);
        chk("busy_drain", busy, 1);
        if (prev_stall) chk("stall_hold", out_data, prev_data);
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        prev_stall = !out_ready;
        prev_data  = out_data;
      end else begin
        prev_stall = 0;
      end
    end
  end

  // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random. abort_at >= 0 resets mid-sort.
  task automatic run_block(input int mode, input int abort_at);
    int i, g;
    bit acc;
    model();
    i = 0; g = 0;
    while (i < N && g < 200) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = in_valid ? blk[i] : 8'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      g++;
    end
    in_valid = 1'b0;
    if (g >= 200) chk("load_timeout", 1, 0);
    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge clk);
      chk("busy_sort", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_phases", sort_phases, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    for (int k = 0; k < N; k++) exp_q.push_back(srt[k]);
    for (int j = 0; j < exp_k; j++) begin
      chk("no_early_valid", out_valid, 0);
      if (j == 0) chk("busy_after_load", busy, 1);
      @(posedge clk); #1;
    end
    chk("first_valid", out_valid, 1);
    chk("sort_phases", sort_phases, exp_k);
    g = 0;
    while (exp_q.size() > 0 && g < 300) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (g % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      g++;
    end
    out_ready = 1'b0;
    if (g >= 300) chk("drain_timeout", 1, 0);
    if (exp_q.size() > 0) exp_q.delete();
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_out_valid", out_valid, 0);
    chk("post_phases", sort_phases, exp_k);
  endtask

  initial begin
    logic [7:0] lit[8];
    rst = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_phases", sort_phases, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    // Pin the model against hand-worked cases.
    for (int i = 0; i < N; i++) blk[i] = 8'(i);
    model(); chk("model_k_asc", exp_k, 2);
    for (int i = 0; i < N; i++) blk[i] = 8'(7 - i);
    model(); chk("model_k_rev", exp_k, 8);
    for (int i = 0; i < N; i++) blk[i] = 8'hAA;
    model(); chk("model_k_same", exp_k, 2);
    blk = '{8'h51, 8'h12, 8'h31, 8'h02, 8'hF0, 8'h0F, 8'h20, 8'h10};
    lit = '{8'h10, 8'h20, 8'hF0, 8'h31, 8'h51, 8'h02, 8'h12, 8'h0F};
    model();
    for (int i = 0; i < N; i++) chk("model_nibble", srt[i], lit[i]);

    for (int i = 0; i < N; i++) blk[i] = 8'(i);
    run_block(0, -1);
    for (int i = 0; i < N; i++) blk[i] = 8'(7 - i);
    run_block(0, -1);
    blk = '{8'h51, 8'h12, 8'h31, 8'h02, 8'hF0, 8'h0F, 8'h20, 8'h10};
    run_block(0, -1);
    for (int i = 0; i < N; i++) blk[i] = 8'hAA;
    run_block(0, -1);
    for (int i = 0; i < N; i++) blk[i] = 8'(7 - i);
    run_block(1, -1);
    for (int i = 0; i < N; i++) blk[i] = 8'(7 - i);
    run_block(0, 3);
    for (int i = 0; i < N; i++) blk[i] = 8'(i);
    run_block(0, -1);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < N; i++)
        blk[i] = (r % 3 == 0) ? 8'($urandom_range(0, 3) * 8'h11) : 8'($urandom);
      run_block(r % 3, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
